// File: rtl/mac2ring_pkg.sv
// Shared types for the MAC-to-ring receive path: FSM states, drop causes and
// descriptor field positions.
package mac2ring_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT,
        DROP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_BAD,
        CAUSE_OVERSIZE,
        CAUSE_FULL
    } cause_e;

    localparam int LEN_LO = 32;
    localparam int LEN_HI = 47;
    localparam int TS_LO  = 0;
    localparam int TS_HI  = 31;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac2ring_bytecnt.sv
// Byte-mask popcount; counts every set bit, so non-contiguous masks still count.
module mac2ring_bytecnt (
    input  logic [7:0] mask,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, mask[i]};
        end
    end

endmodule

// File: rtl/mac2ring.sv
// 10G MAC receive beats into a circular packet RAM (descriptor + payload).
// Optional feature macro: MAC2RING_TIMESTAMP_EN (cycle timestamp in descriptor).
module mac2ring
    import mac2ring_pkg::*;
#(
    parameter int AW        = 10,
    parameter int MAX_BYTES = 1522
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   mac_rx_data,
    input  logic [7:0]    mac_rx_data_valid,
    input  logic          mac_rx_good_frame,
    input  logic          mac_rx_bad_frame,
    input  logic [AW-1:0] committed_cons,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          activity,
    output logic [AW-1:0] committed_prod,
    output logic [15:0]   frames_ok,
    output logic [15:0]   drop_bad,
    output logic [15:0]   drop_oversize,
    output logic [15:0]   drop_full
);

    state_e        state_q, state_d;
    cause_e        cause_q, cause_d;
    logic [AW-1:0] offset_q, offset_d;
    logic [AW-1:0] prod_q, prod_d;
    logic [AW-1:0] cprod_q, cprod_d;
    logic [15:0]   bytes_q, bytes_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]   wr_data_q, wr_data_d;
    logic          commit_pend_q, commit_pend_d;
    logic [15:0]   frames_q, frames_d;
    logic [15:0]   bad_q, bad_d;
    logic [15:0]   ovs_q, ovs_d;
    logic [15:0]   full_q, full_d;

    logic [3:0]    beat_bytes;
    logic          has_beat;
    logic          eof;
    logic [AW-1:0] cur_off;
    logic [AW-1:0] free_words;
    logic [15:0]   cur_bytes;
    logic [16:0]   sum_bytes;
    logic          trig;
    cause_e        trig_cause;
    logic          count_now;
    cause_e        count_cause;
    logic [31:0]   desc_ts;
    logic [63:0]   desc_word;

    mac2ring_bytecnt u_bytecnt (
        .mask  (mac_rx_data_valid),
        .count (beat_bytes)
    );

`ifdef MAC2RING_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_lat_q, ts_lat_d;

    always_comb begin
        ts_d     = ts_q + 32'd1;
        ts_lat_d = (state_q == IDLE && has_beat) ? ts_q : ts_lat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q     <= ts_d;
            ts_lat_q <= ts_lat_d;
        end
    end

    assign desc_ts = ts_lat_q;
`else
    assign desc_ts = '0;
`endif

    // IDLE treats a new start-of-frame as offset 1 with no bytes seen yet.
    assign has_beat   = (mac_rx_data_valid != 8'd0);
    assign eof        = mac_rx_good_frame | mac_rx_bad_frame;
    assign cur_off    = (state_q == IDLE) ? AW'(1) : offset_q;
    assign cur_bytes  = (state_q == IDLE) ? 16'd0 : bytes_q;
    assign sum_bytes  = {1'b0, cur_bytes} + {13'd0, beat_bytes};
    assign free_words = committed_cons - prod_q - AW'(1);

    always_comb begin
        desc_word                = '0;
        desc_word[LEN_HI:LEN_LO] = bytes_q;
        desc_word[TS_HI:TS_LO]   = desc_ts;
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        offset_d      = offset_q;
        bytes_d       = bytes_q;
        prod_d        = prod_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        commit_pend_d = 1'b0;
        trig          = 1'b0;
        trig_cause    = CAUSE_FULL;
        count_now     = 1'b0;
        count_cause   = cause_q;
        unique case (state_q)
            IDLE, RECV: begin
                if (state_q == RECV || has_beat) begin
                    if (has_beat && cur_off >= free_words) begin
                        trig       = 1'b1;
                        trig_cause = CAUSE_FULL;
                    end else if (sum_bytes > 17'(MAX_BYTES)) begin
                        trig       = 1'b1;
                        trig_cause = CAUSE_OVERSIZE;
                    end else if (mac_rx_bad_frame || (mac_rx_good_frame && sum_bytes == '0)) begin
                        count_now   = 1'b1;
                        count_cause = CAUSE_BAD;
                        state_d     = IDLE;
                    end else begin
                        if (has_beat) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = prod_q + cur_off;
                            wr_data_d = mac_rx_data;
                        end
                        offset_d = cur_off + AW'(has_beat);
                        bytes_d  = sum_bytes[15:0];
                        state_d  = mac_rx_good_frame ? COMMIT : RECV;
                    end
                    if (trig) begin
                        cause_d     = trig_cause;
                        count_cause = trig_cause;
                        count_now   = eof;
                        state_d     = eof ? IDLE : DROP;
                    end
                end
            end
            COMMIT: begin
                // offset_q is one past the last payload word, i.e. the frame footprint.
                wr_en_d       = 1'b1;
                wr_addr_d     = prod_q;
                wr_data_d     = desc_word;
                prod_d        = prod_q + offset_q;
                commit_pend_d = 1'b1;
                state_d       = IDLE;
                if (has_beat) begin
                    count_now   = 1'b1;
                    count_cause = CAUSE_BAD;
                end
            end
            DROP: begin
                if (eof) begin
                    count_now   = 1'b1;
                    count_cause = cause_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The public pointer lags the internal one so the descriptor lands in RAM first.
    always_comb begin
        cprod_d  = prod_q;
        frames_d = commit_pend_q ? sat_inc(frames_q) : frames_q;
        bad_d    = (count_now && count_cause == CAUSE_BAD)      ? sat_inc(bad_q)  : bad_q;
        ovs_d    = (count_now && count_cause == CAUSE_OVERSIZE) ? sat_inc(ovs_q)  : ovs_q;
        full_d   = (count_now && count_cause == CAUSE_FULL)     ? sat_inc(full_q) : full_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cause_q       <= CAUSE_BAD;
            offset_q      <= '0;
            prod_q        <= '0;
            cprod_q       <= '0;
            bytes_q       <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            commit_pend_q <= 1'b0;
            frames_q      <= '0;
            bad_q         <= '0;
            ovs_q         <= '0;
            full_q        <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            offset_q      <= offset_d;
            prod_q        <= prod_d;
            cprod_q       <= cprod_d;
            bytes_q       <= bytes_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            commit_pend_q <= commit_pend_d;
            frames_q      <= frames_d;
            bad_q         <= bad_d;
            ovs_q         <= ovs_d;
            full_q        <= full_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign activity       = wr_en_q;
    assign committed_prod = cprod_q;
    assign frames_ok      = frames_q;
    assign drop_bad       = bad_q;
    assign drop_oversize  = ovs_q;
    assign drop_full      = full_q;

endmodule

// File: tb/tb_mac2ring.sv
// Directed bench for mac2ring: frame-level ring model plus hand-pinned checkpoints.
module tb_mac2ring;

    localparam int AW        = 10;
    localparam int MAX_BYTES = 1522;
    localparam int RING      = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   mac_rx_data = '0;
    logic [7:0]    mac_rx_data_valid = '0;
    logic          mac_rx_good_frame = 1'b0;
    logic          mac_rx_bad_frame = 1'b0;
    logic [AW-1:0] committed_cons = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          activity;
    logic [AW-1:0] committed_prod;
    logic [15:0]   frames_ok, drop_bad, drop_oversize, drop_full;

    mac2ring #(.AW(AW), .MAX_BYTES(MAX_BYTES)) dut (
        .clk               (clk),
        .rst               (rst),
        .mac_rx_data       (mac_rx_data),
        .mac_rx_data_valid (mac_rx_data_valid),
        .mac_rx_good_frame (mac_rx_good_frame),
        .mac_rx_bad_frame  (mac_rx_bad_frame),
        .committed_cons    (committed_cons),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .activity          (activity),
        .committed_prod    (committed_prod),
        .frames_ok         (frames_ok),
        .drop_bad          (drop_bad),
        .drop_oversize     (drop_oversize),
        .drop_full         (drop_full)
    );

    always #5 clk = ~clk;

`ifdef MAC2RING_TIMESTAMP_EN
    localparam logic [63:0] DESC_MASK = 64'hFFFF_FFFF_0000_0000;
`else
    localparam logic [63:0] DESC_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    typedef struct {
        int          addr;
        logic [63:0] data;
        logic [63:0] mask;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_prod = 0, exp_ok = 0, exp_bad = 0, exp_ovs = 0, exp_full = 0;
    int  fid = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input int f, input int k);
        return {32'(f), 32'(k)} ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    function automatic void push_wr(input int addr, input logic [63:0] data, input logic [63:0] m);
        wr_t e;
        e.addr = addr % RING;
        e.data = data;
        e.mask = m;
        exp_q.push_back(e);
    endfunction

    // Every RAM write must match the next expected write, in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                check("activity_on_write", 64'(activity), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", wr_data & e.mask, e.data & e.mask);
                end
            end else begin
                check("activity_idle", 64'(activity), 64'd0);
            end
        end
    end

    task automatic beat(input logic [63:0] d, input logic [7:0] m, input logic g, input logic b);
        mac_rx_data       = d;
        mac_rx_data_valid = m;
        mac_rx_good_frame = g;
        mac_rx_bad_frame  = b;
        @(posedge clk);
        #1;
        mac_rx_data       = '0;
        mac_rx_data_valid = '0;
        mac_rx_good_frame = 1'b0;
        mac_rx_bad_frame  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model the frame from the ring rules, then drive it.
    task automatic send_frame(input int n, input logic [7:0] last_mask, input bit is_bad, input bit sep_strobe);
        int          free, bytes, cause;
        bit          dropped;
        logic [7:0]  m;
        fid++;
        free    = (int'(committed_cons) - exp_prod - 1) & (RING - 1);
        bytes   = 0;
        cause   = 0;
        dropped = 0;
        for (int k = 1; k <= n; k++) begin
            m = (k == n) ? last_mask : 8'hFF;
            if (!dropped) begin
                if (k >= free) begin
                    dropped = 1; cause = 3;
                end else if (bytes + $countones(m) > MAX_BYTES) begin
                    dropped = 1; cause = 2;
                end else if (k == n && !sep_strobe && is_bad) begin
                    dropped = 1; cause = 1;
                end else begin
                    push_wr(exp_prod + k, data_of(fid, k), '1);
                    bytes += $countones(m);
                end
            end
        end
        if (dropped) begin
            if (cause == 1) exp_bad++;
            else if (cause == 2) exp_ovs++;
            else exp_full++;
        end else if (is_bad) begin
            exp_bad++;
        end else begin
            push_wr(exp_prod, {16'd0, 16'(bytes), 32'd0}, DESC_MASK);
            exp_prod = (exp_prod + n + 1) % RING;
            exp_ok++;
        end
        for (int k = 1; k <= n; k++) begin
            m = (k == n) ? last_mask : 8'hFF;
            beat(data_of(fid, k), m, (k == n && !sep_strobe && !is_bad), (k == n && !sep_strobe && is_bad));
        end
        if (sep_strobe) beat('0, 8'h00, !is_bad, is_bad);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_prod"},       64'(committed_prod), 64'(exp_prod));
        check({tag, "_frames_ok"},  64'(frames_ok),      64'(exp_ok));
        check({tag, "_drop_bad"},   64'(drop_bad),       64'(exp_bad));
        check({tag, "_drop_ovs"},   64'(drop_oversize),  64'(exp_ovs));
        check({tag, "_drop_full"},  64'(drop_full),      64'(exp_full));
        check({tag, "_pending_wr"}, 64'(exp_q.size()),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r, n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check_counters("reset");

        // 64-byte frame into an empty ring, with pinned commit timing.
        send_frame(8, 8'hFF, 0, 0);
        @(posedge clk); #1;
        check("t1_desc_addr", 64'(wr_addr), 64'd0);
        check("t1_desc_len", 64'(wr_data[47:32]), 64'd64);
        check("t1_prod_before", 64'(committed_prod), 64'd0);
        @(posedge clk); #1;
        check("t1_prod_after", 64'(committed_prod), 64'd9);
        check("t1_frames_ok", 64'(frames_ok), 64'd1);
        idle(2);
        check_counters("t1");

        // 61-byte frame, then a bad frame, then a restart at the same slot.
        send_frame(8, 8'h1F, 0, 0);
        @(posedge clk); #1;
        check("t2_desc_len", 64'(wr_data[47:32]), 64'd61);
        idle(2);
        check_counters("t2");
        send_frame(3, 8'hFF, 1, 0);
        idle(3);
        check("t3_drop_bad", 64'(drop_bad), 64'd1);
        check("t3_prod", 64'(committed_prod), 64'd18);
        check_counters("t3");
        send_frame(2, 8'hFF, 0, 0);
        idle(3);
        check("t3b_prod", 64'(committed_prod), 64'd21);
        check_counters("t3b");

        // Ring nearly full: 4 free words, 20-beat frame.
        committed_cons = AW'((exp_prod + 5) % RING);
        send_frame(20, 8'hFF, 0, 0);
        idle(3);
        check("t4_drop_full", 64'(drop_full), 64'd1);
        check("t4_prod", 64'(committed_prod), 64'd21);
        check_counters("t4");
        committed_cons = AW'(exp_prod);
        send_frame(8, 8'hFF, 0, 0);
        idle(3);
        check("t4b_prod", 64'(committed_prod), 64'd30);
        check_counters("t4b");

        // Full triggered on the end-of-frame beat itself.
        committed_cons = AW'((exp_prod + 3) % RING);
        send_frame(2, 8'hFF, 0, 0);
        idle(3);
        check("t8_drop_full", 64'(drop_full), 64'd2);
        check_counters("t8");

        // Strobe-only end of frame.
        committed_cons = AW'(exp_prod);
        send_frame(3, 8'h0F, 0, 1);
        idle(3);
        check("t9_prod", 64'(committed_prod), 64'd34);
        check_counters("t9");

        // Beat during the commit cycle violates the gap.
        send_frame(2, 8'hFF, 0, 0);
        beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 1'b0);
        exp_bad++;
        idle(3);
        check("t10_drop_bad", 64'(drop_bad), 64'd2);
        check_counters("t10");

        // 1600-byte frame against 1522-byte limit, then a normal frame.
        committed_cons = AW'(exp_prod);
        send_frame(200, 8'hFF, 0, 0);
        idle(3);
        check("t5_drop_ovs", 64'(drop_oversize), 64'd1);
        check_counters("t5");
        send_frame(8, 8'hFF, 0, 0);
        idle(3);
        check_counters("t5b");

        // Advance the ring to 1020, then wrap a 10-beat frame.
        for (int it = 0; it < 20 && exp_prod != 1020; it++) begin
            committed_cons = AW'(exp_prod);
            r = 1020 - exp_prod;
            n = (r >= 110) ? 108 : r - 1;
            send_frame(n, 8'hFF, 0, 0);
            idle(2);
        end
        idle(2);
        check("t6_fill_prod", 64'(committed_prod), 64'd1020);
        committed_cons = AW'(exp_prod);
        send_frame(10, 8'hFF, 0, 0);
        idle(3);
        check("t6_wrap_prod", 64'(committed_prod), 64'd7);
        check_counters("t6");

        // Reset in the middle of a frame.
        committed_cons = AW'(exp_prod);
        fid++;
        for (int k = 1; k <= 3; k++) push_wr(exp_prod + k, data_of(fid, k), '1);
        for (int k = 1; k <= 3; k++) beat(data_of(fid, k), 8'hFF, 1'b0, 1'b0);
        idle(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_wr_en", 64'(wr_en), 64'd0);
        check("t7_wr_addr", 64'(wr_addr), 64'd0);
        check("t7_wr_data", wr_data, 64'd0);
        exp_prod = 0; exp_ok = 0; exp_bad = 0; exp_ovs = 0; exp_full = 0;
        committed_cons = '0;
        check_counters("t7_reset");
        idle(3);
        check_counters("t7_quiet");
        send_frame(8, 8'hFF, 0, 0);
        idle(3);
        check("t7_prod", 64'(committed_prod), 64'd9);
        check_counters("t7_after");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
